// File: rtl/uart_tx_if.sv
// FIFO-to-serializer pop handshake: combinational FIFO head plus empty flag in,
// pop request back out.
interface uart_tx_if #(
  parameter int DATA_SIZE = 8
);
  logic                 tx_empty;
  logic [DATA_SIZE-1:0] tx_data;
  logic                 tx_rd;

  // master: serializer side (consumes the head, issues the pop)
  modport master (input tx_empty, input tx_data, output tx_rd);
  // slave: FIFO side
  modport slave  (output tx_empty, output tx_data, input tx_rd);
endinterface

// File: rtl/uart_tx.sv
// UART transmit serializer: pops a word from the TX FIFO and shifts it out LSB first
// as start / data / optional parity / stop, paced by the shared oversampling tick.
module uart_tx #(
  parameter int DATA_SIZE  = 8,
  parameter int OVERSAMPLE = 16,
  parameter int SB_TICK    = 16,
  parameter int PARITY_EN  = 0,
  parameter int PARITY_ODD = 0
) (
  input  logic      clk,
  input  logic      reset_n,
  input  logic      s_tick,
  uart_tx_if.master fifo,
  output logic      tx,
  output logic      tx_busy,
  output logic      tx_done_tick
);
  localparam int TMAX = (OVERSAMPLE > SB_TICK) ? OVERSAMPLE : SB_TICK;
  localparam int TW   = (TMAX > 1) ? $clog2(TMAX) : 1;
  localparam int BW   = (DATA_SIZE > 1) ? $clog2(DATA_SIZE) : 1;

  localparam logic [TW-1:0] OS_LAST  = TW'(OVERSAMPLE - 1);
  localparam logic [TW-1:0] SB_LAST  = TW'(SB_TICK - 1);
  localparam logic [BW-1:0] BIT_LAST = BW'(DATA_SIZE - 1);

  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;

  state_t               state_q, state_d;
  logic [TW-1:0]        tick_q, tick_d;
  logic [BW-1:0]        bit_q, bit_d;
  logic [DATA_SIZE-1:0] shift_q, shift_d;
  logic                 par_q, par_d;
  logic                 tx_q, tx_d;
  logic                 done_q;
  logic                 last_stop, load_ok, pop;

  // The final stop tick doubles as a load slot so frames can run back to back.
  assign last_stop = (state_q == STOP) && (tick_q == SB_LAST);
  assign load_ok   = (state_q == IDLE) || last_stop;
  assign pop       = s_tick & ~fifo.tx_empty & load_ok;
  assign fifo.tx_rd = pop;

  always_comb begin
    state_d = state_q;
    tick_d  = tick_q;
    bit_d   = bit_q;
    shift_d = shift_q;
    par_d   = par_q;
    if (s_tick) begin
      case (state_q)
        IDLE: begin
          if (pop) begin
            state_d = START;
            tick_d  = '0;
            shift_d = fifo.tx_data;
            par_d   = (^fifo.tx_data) ^ (PARITY_ODD != 0);
          end
        end
        START: begin
          if (tick_q == OS_LAST) begin
            state_d = DATA;
            tick_d  = '0;
            bit_d   = '0;
          end else begin
            tick_d = tick_q + 1'b1;
          end
        end
        DATA: begin
          if (tick_q == OS_LAST) begin
            tick_d  = '0;
            shift_d = shift_q >> 1;
            if (bit_q == BIT_LAST) state_d = (PARITY_EN != 0) ? PARITY : STOP;
            else                   bit_d   = bit_q + 1'b1;
          end else begin
            tick_d = tick_q + 1'b1;
          end
        end
        PARITY: begin
          if (tick_q == OS_LAST) begin
            state_d = STOP;
            tick_d  = '0;
          end else begin
            tick_d = tick_q + 1'b1;
          end
        end
        STOP: begin
          if (tick_q == SB_LAST) begin
            tick_d = '0;
            if (pop) begin
              state_d = START;
              shift_d = fifo.tx_data;
              par_d   = (^fifo.tx_data) ^ (PARITY_ODD != 0);
            end else begin
              state_d = IDLE;
            end
          end else begin
            tick_d = tick_q + 1'b1;
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  // Line level is decoded from the next state so the registered tx tracks it exactly.
  always_comb begin
    tx_d = 1'b1;
    case (state_d)
      START:   tx_d = 1'b0;
      DATA:    tx_d = shift_d[0];
      PARITY:  tx_d = par_d;
      default: tx_d = 1'b1;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= IDLE;
      tick_q  <= '0;
      bit_q   <= '0;
      shift_q <= '0;
      par_q   <= 1'b0;
      tx_q    <= 1'b1;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      tick_q  <= tick_d;
      bit_q   <= bit_d;
      shift_q <= shift_d;
      par_q   <= par_d;
      tx_q    <= tx_d;
      done_q  <= s_tick & last_stop;
    end
  end

  assign tx           = tx_q;
  assign tx_busy      = (state_q != IDLE);
  assign tx_done_tick = done_q;
endmodule

// File: tb/tb_uart_tx.sv
// Scoreboard bench for uart_tx: three configurations (8N1, 8E1, 8O1 with 2 stop bits)
// share clk, reset and s_tick; a line decoder per config checks frames against a queue.
module tb_uart_tx;
  localparam int NCFG = 3;
  localparam int DS   = 8;
  localparam int OS   = 16;
  localparam int DIV  = 4;

  logic clk = 1'b0;
  logic reset_n;
  logic s_tick = 1'b0;

  logic tx_w [NCFG];
  logic busy_w [NCFG];
  logic done_w [NCFG];
  logic rd_w [NCFG];

  logic [7:0] fifo_q [NCFG][$];
  logic [7:0] exp_q  [NCFG][$];
  int         starts_q [NCFG][$];
  int pops [NCFG], pushed [NCFG], frames [NCFG], dones [NCFG], rd_viol [NCFG];
  int checks = 0, errors = 0;

  always #5 clk = ~clk;

  initial begin
    forever begin
      repeat (DIV - 1) @(posedge clk);
      #1 s_tick = 1'b1;
      @(posedge clk);
      #1 s_tick = 1'b0;
    end
  end

  function automatic int cfg_pe(input int g);  return (g > 0) ? 1 : 0;    endfunction
  function automatic int cfg_po(input int g);  return (g == 2) ? 1 : 0;   endfunction
  function automatic int cfg_sb(input int g);  return (g == 2) ? 32 : 16; endfunction
  function automatic int flen(input int g);
    return OS * (1 + DS + cfg_pe(g)) + cfg_sb(g);
  endfunction

  task automatic chk(input bit ok, input string name, input longint got, input longint exp);
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endtask

  task automatic push(input int g, input logic [7:0] w);
    fifo_q[g].push_back(w);
    exp_q[g].push_back(w);
    pushed[g]++;
  endtask

  for (genvar g = 0; g < NCFG; g++) begin : cfg
    localparam int PE  = (g > 0) ? 1 : 0;
    localparam int PO  = (g == 2) ? 1 : 0;
    localparam int SBT = (g == 2) ? 32 : 16;
    localparam int FL  = OS * (1 + DS + PE) + SBT;

    uart_tx_if #(.DATA_SIZE(DS)) tif ();

    uart_tx #(
      .DATA_SIZE(DS), .OVERSAMPLE(OS), .SB_TICK(SBT), .PARITY_EN(PE), .PARITY_ODD(PO)
    ) dut (
      .clk(clk), .reset_n(reset_n), .s_tick(s_tick), .fifo(tif.master),
      .tx(tx_w[g]), .tx_busy(busy_w[g]), .tx_done_tick(done_w[g])
    );

    assign rd_w[g] = tif.tx_rd;

    // FIFO model: pop decided from the settled tx_rd, head updated just after the edge
    initial begin : fifo_drv
      logic rd;
      tif.tx_empty = 1'b1;
      tif.tx_data  = '0;
      forever begin
        @(negedge clk);
        rd = tif.tx_rd;
        if (rd && (!s_tick || tif.tx_empty)) rd_viol[g]++;
        @(posedge clk);
        #1;
        if (rd) begin
          pops[g]++;
          if (fifo_q[g].size() > 0) void'(fifo_q[g].pop_front());
        end
        tif.tx_empty = (fifo_q[g].size() == 0);
        tif.tx_data  = (fifo_q[g].size() > 0) ? fifo_q[g][0] : 8'($urandom);
      end
    end

    // Line decoder: one sample per s_tick, frame begins at the first low sample
    initial begin : mon
      logic       smp [$];
      logic [7:0] w, got;
      logic       e;
      int         tk, last_end, bad;
      bit         done_seen;
      tk = 0; last_end = -1; done_seen = 1'b0;
      forever begin
        @(negedge clk);
        if (!reset_n) begin
          if (smp.size() > 0 && exp_q[g].size() > 0) void'(exp_q[g].pop_front());
          smp.delete();
          continue;
        end
        if (done_w[g]) begin
          dones[g]++;
          chk(!done_seen && tk == last_end, $sformatf("cfg%0d done_tick tick", g), tk, last_end);
          done_seen = 1'b1;
        end
        if (s_tick) begin
          tk++;
          if (smp.size() > 0 || tx_w[g] == 1'b0) begin
            if (smp.size() == 0) starts_q[g].push_back(tk);
            smp.push_back(tx_w[g]);
          end
          if (smp.size() == FL) begin
            frames[g]++;
            done_seen = 1'b0;
            last_end  = tk;
            for (int b = 0; b < DS; b++) got[b] = smp[OS * (b + 1) + OS / 2];
            if (exp_q[g].size() == 0) begin
              chk(1'b0, $sformatf("cfg%0d unexpected frame", g), got, 0);
            end else begin
              w = exp_q[g].pop_front();
              bad = 0;
              for (int i = 0; i < FL; i++) begin
                if (i < OS)                           e = 1'b0;
                else if (i < OS * (1 + DS))           e = w[i / OS - 1];
                else if (PE != 0 && i < OS * (2 + DS)) e = (^w) ^ (PO != 0);
                else                                  e = 1'b1;
                if (smp[i] !== e) bad++;
              end
              chk(bad == 0, $sformatf("cfg%0d frame (%0d bad samples)", g, bad), got, w);
            end
            smp.delete();
          end
        end
      end
    end
  end

  task automatic wait_idle(input int budget, input string name);
    int  n;
    bit  idle;
    n = 0;
    do begin
      @(negedge clk);
      n++;
      idle = 1'b1;
      for (int g = 0; g < NCFG; g++)
        if (exp_q[g].size() != 0 || fifo_q[g].size() != 0 || busy_w[g]) idle = 1'b0;
    end while (!idle && n < budget);
    chk(idle, {name, " drain cycles"}, n, budget);
  endtask

  task automatic quiet(input int ncyc, input string name);
    int viol [NCFG];
    for (int g = 0; g < NCFG; g++) viol[g] = 0;
    repeat (ncyc) begin
      @(negedge clk);
      for (int g = 0; g < NCFG; g++)
        if (rd_w[g] || !tx_w[g] || busy_w[g] || done_w[g]) viol[g]++;
    end
    for (int g = 0; g < NCFG; g++)
      chk(viol[g] == 0, $sformatf("cfg%0d %s idle violations", g, name), viol[g], 0);
  endtask

  initial begin : main
    int n, cnt;
    reset_n = 1'b0;
    #20;
    for (int g = 0; g < NCFG; g++)
      chk({tx_w[g], busy_w[g], done_w[g], rd_w[g]} == 4'b1000,
          $sformatf("cfg%0d reset {tx,busy,done,rd}", g),
          {tx_w[g], busy_w[g], done_w[g], rd_w[g]}, 4'b1000);
    repeat (3) @(posedge clk);
    #1 reset_n = 1'b1;

    quiet(1000, "empty fifo");

    @(negedge clk);
    for (int g = 0; g < NCFG; g++) push(g, 8'hA5);
    wait_idle(4000, "single A5");

    @(negedge clk);
    for (int g = 0; g < NCFG; g++) begin push(g, 8'h00); push(g, 8'hFF); end
    wait_idle(6000, "pair 00/FF");
    for (int g = 0; g < NCFG; g++) begin
      n = starts_q[g].size();
      if (n >= 2)
        chk(starts_q[g][n-1] - starts_q[g][n-2] == flen(g),
            $sformatf("cfg%0d back-to-back spacing", g), starts_q[g][n-1] - starts_q[g][n-2], flen(g));
      else
        chk(1'b0, $sformatf("cfg%0d back-to-back frame count", g), n, 2);
    end

    @(negedge clk);
    for (int g = 0; g < NCFG; g++) push(g, 8'h07);
    wait_idle(4000, "parity 07");

    for (int k = 0; k < 30; k++) begin
      @(negedge clk);
      for (int g = 0; g < NCFG; g++) push(g, 8'($urandom));
      repeat ($urandom_range(0, 600)) @(negedge clk);
    end
    wait_idle(40000, "random");

    // mid-frame abort during data bit 3 of 0x3C
    @(negedge clk);
    for (int g = 0; g < NCFG; g++) push(g, 8'h3C);
    n = 0;
    while (!rd_w[0] && n < 200) begin @(negedge clk); n++; end
    chk(rd_w[0], "pop of 3C", rd_w[0], 1);
    cnt = 0;
    while (cnt < OS + 3 * OS + OS / 2) begin @(negedge clk); if (s_tick) cnt++; end
    @(posedge clk);
    #2 reset_n = 1'b0;
    #1;
    for (int g = 0; g < NCFG; g++)
      chk(tx_w[g] == 1'b1 && busy_w[g] == 1'b0, $sformatf("cfg%0d async abort {tx,busy}", g),
          {tx_w[g], busy_w[g]}, 2'b10);
    repeat (5) @(posedge clk);
    #1 reset_n = 1'b1;
    quiet(200, "post-abort");
    for (int g = 0; g < NCFG; g++)
      chk(pops[g] == pushed[g], $sformatf("cfg%0d no re-pop", g), pops[g], pushed[g]);
    @(negedge clk);
    for (int g = 0; g < NCFG; g++) push(g, 8'h5A);
    wait_idle(4000, "after abort");
    repeat (20) @(negedge clk);

    for (int g = 0; g < NCFG; g++) begin
      chk(frames[g] == pushed[g] - 1, $sformatf("cfg%0d frames", g), frames[g], pushed[g] - 1);
      chk(dones[g] == frames[g], $sformatf("cfg%0d done pulses", g), dones[g], frames[g]);
      chk(pops[g] == pushed[g], $sformatf("cfg%0d pops", g), pops[g], pushed[g]);
      chk(rd_viol[g] == 0, $sformatf("cfg%0d tx_rd protocol", g), rd_viol[g], 0);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/uart_tx.md
Name: uart_tx

Overview:
UART transmit serializer that sits directly downstream of the transmit-side uart_fifo. It pops one word from the FIFO whenever the FIFO is non-empty and the serializer is free. It then shifts the word out on the serial line, LSB first, as start / data / optional parity / stop bits. Bit timing is driven by the shared baud oversampling tick s_tick, which is the same tick that qualifies FIFO pointer updates.

Parameters:
DATA_SIZE, 8, data bits per frame; must match the FIFO DATA_SIZE.
OVERSAMPLE, 16, s_tick pulses per start, data and parity bit.
SB_TICK, 16, s_tick pulses for the stop period (16 = 1 stop bit, 24 = 1.5, 32 = 2).
PARITY_EN, 0, 1 inserts a parity bit after the data bits.
PARITY_ODD, 0, 0 = even parity, 1 = odd parity; ignored when PARITY_EN = 0.

Ports:
clk  input  1  system clock
reset_n  input  1  asynchronous active-low reset
s_tick  input  1  one-clk baud oversampling enable pulse
tx_empty  input  1  FIFO empty flag
tx_data  input  DATA_SIZE  FIFO r_data; combinational head of the FIFO
tx_rd  output  1  FIFO pop request
tx  output  1  serial line, idle high
tx_busy  output  1  high while a frame is in progress
tx_done_tick  output  1  one-clk pulse at the end of each frame

Behaviour:
- Single clock domain, clk. Reset is asynchronous and active-low on reset_n.
- All state advances only in clk cycles where s_tick = 1. Between ticks, all registers hold.
- Reset values: state = IDLE, tx = 1, tx_busy = 0, tx_done_tick = 0, tick counter = 0, bit counter = 0.
- Asserting reset_n low mid-frame aborts the frame immediately: tx returns to 1 and the word is lost, with no re-pop.
- tx is registered, so it is glitch-free.
- Pop handshake:
  - tx_rd is combinational: tx_rd = s_tick & ~tx_empty & load_ok, where load_ok = (state == IDLE) or (state == STOP with tick count == SB_TICK-1).
  - tx_rd is never high without s_tick, because the FIFO only advances its read pointer on s_tick.
  - At most one pop per frame.
  - The shift register latches tx_data in the same cycle that tx_rd is high; tx_data is valid because it comes from the combinational FIFO head.
  - The parity bit is computed at latch time: XOR of the data bits, inverted when PARITY_ODD = 1.
- FSM states and transitions:
  - IDLE: tx = 1. On a pop, go to START with tick count = 0.
  - START: tx = 0. The tick count increments each s_tick. At OVERSAMPLE-1, go to DATA with tick count = 0 and bit count = 0.
  - DATA: tx = shift[0]. At tick count OVERSAMPLE-1, shift right and increment the bit count. After bit DATA_SIZE-1, go to PARITY if PARITY_EN = 1, otherwise go to STOP.
  - PARITY: tx = parity bit for OVERSAMPLE ticks, then go to STOP.
  - STOP: tx = 1 for SB_TICK ticks. On the last tick:
    - tx_done_tick pulses for exactly one clk.
    - If tx_empty = 0, pop the next word and go directly to START (back-to-back frames, no idle gap).
    - Otherwise go to IDLE.
- tx_busy = 1 in every state except IDLE.
- Frame length in ticks = OVERSAMPLE*(1 + DATA_SIZE + PARITY_EN) + SB_TICK; 8N1 at 16x = 160 ticks.
- Counter widths: tick counter is $clog2(max(OVERSAMPLE, SB_TICK)) bits; bit counter is $clog2(DATA_SIZE) bits. Counters wrap only by explicit reset to 0, never by overflow.
- If tx_empty falls between ticks, the pop waits for the next s_tick; no partial-tick start.
- tx_data changing while a frame is in progress has no effect on the frame.

Test Plan:
- 8N1, s_tick every 4 clk, FIFO holds 0xA5 -> one tx_rd pulse coincident with s_tick; tx sequence is 0,1,0,1,0,0,1,0,1,1 with each bit lasting 16 ticks (64 clk); tx_done_tick pulses once at tick 160; tx_busy falls; FIFO goes empty.
- FIFO holds 0x00 then 0xFF -> second tx_rd occurs on the final stop tick of frame 1; the start bit of frame 2 begins on the next tick with no extra idle high; total 320 ticks; 2 tx_done_tick pulses.
- PARITY_EN = 1, PARITY_ODD = 0, word 0x07 -> parity bit = 1. PARITY_ODD = 1, word 0x07 -> parity bit = 0. Frame length is 176 ticks.
- tx_empty held at 1 for 1000 clk with s_tick running -> tx_rd never asserted; tx stays 1; tx_busy stays 0.
- Reset_n pulsed low during data bit 3 of 0x3C -> tx = 1 and tx_busy = 0 asynchronously; after release, the next FIFO word starts a clean frame on the next s_tick.
- SB_TICK = 32 with word 0x55 -> stop high lasts 32 ticks; tx_done_tick fires at tick 176.
